// File: rtl/fp_div_iter.sv
// fp_div_iter: iterative restoring floating-point divider with a valid/ready handshake.
// One operation in flight. RNE rounding, flush-to-zero on underflow, subnormal inputs read
// as signed zero. Flags are {invalid, div_by_zero, overflow, underflow, inexact}.
module fp_div_iter #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10,
    localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] q,
    output logic [4:0]   flags,
    output logic         busy
);
    localparam int unsigned BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EW    = EXP_W + 2;
    localparam int unsigned CNT_W = $clog2(MAN_W + 3);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(MAN_W + 2);
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W - 1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StCheck, StIter, StNormRnd, StDone} state_e;

    state_e                 state_q, state_d;
    logic [W-1:0]           a_q, b_q;
    logic signed [EW-1:0]   exp_q;
    logic [MAN_W+1:0]       rem_q;
    logic [MAN_W:0]         div_q;
    logic [MAN_W+2:0]       qint_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [W-1:0]           q_q;
    logic [4:0]             flags_q;

    // Operand fields; a_q/b_q stay valid for the whole operation.
    logic                   sa, sb, sign;
    logic [EXP_W-1:0]       ea, eb;
    logic [MAN_W-1:0]       fa, fb;
    logic                   a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign {sa, ea, fa} = a_q;
    assign {sb, eb, fb} = b_q;
    assign sign   = sa ^ sb;
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);

    logic                   is_special;
    logic [W-1:0]           spec_q;
    logic [4:0]             spec_flags;

    // Special-case classification in priority order.
    always_comb begin
        is_special = 1'b1;
        spec_q     = '0;
        spec_flags = '0;
        if (a_nan || b_nan) begin
            spec_q        = QNAN;
            spec_flags[4] = (a_nan && !fa[MAN_W-1]) || (b_nan && !fb[MAN_W-1]);
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_q        = QNAN;
            spec_flags[4] = 1'b1;
        end else if (a_inf) begin
            spec_q = {sign, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            spec_q = {sign, {(W - 1){1'b0}}};
        end else if (b_zero) begin
            spec_q        = {sign, EXP_ONES, {MAN_W{1'b0}}};
            spec_flags[3] = 1'b1;
        end else if (a_zero) begin
            spec_q = {sign, {(W - 1){1'b0}}};
        end else begin
            is_special = 1'b0;
        end
    end

    logic signed [EW-1:0]   exp_init;
    logic                   qbit;
    logic [MAN_W+1:0]       rem_sub, rem_next;

    // Biased exponent difference and one restoring-division step.
    always_comb begin
        exp_init = $signed(EW'(ea)) - $signed(EW'(eb)) + $signed(EW'(BIAS));
        qbit     = (rem_q >= {1'b0, div_q});
        rem_sub  = qbit ? (rem_q - {1'b0, div_q}) : rem_q;
        rem_next = rem_sub << 1;
    end

    logic signed [EW-1:0]   exp_n, exp_r;
    logic [MAN_W-1:0]       mant_n;
    logic [MAN_W:0]         mant_r;
    logic                   guard, sticky, round_up;
    logic [W-1:0]           norm_q;
    logic [4:0]             norm_flags;

    // Normalise, round to nearest even, then range-check the final exponent.
    always_comb begin
        exp_n  = exp_q;
        mant_n = qint_q[MAN_W+1:2];
        guard  = qint_q[1];
        sticky = qint_q[0] | (rem_q != '0);
        if (!qint_q[MAN_W+2]) begin
            exp_n  = exp_q - EW'(1);
            mant_n = qint_q[MAN_W:1];
            guard  = qint_q[0];
            sticky = (rem_q != '0);
        end
        round_up   = guard & (sticky | mant_n[0]);
        mant_r     = {1'b0, mant_n} + {{MAN_W{1'b0}}, round_up};
        exp_r      = mant_r[MAN_W] ? (exp_n + EW'(1)) : exp_n;
        norm_q     = {sign, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
        norm_flags = {4'b0000, guard | sticky};
        if (exp_r >= EXP_MAX) begin
            norm_q     = {sign, EXP_ONES, {MAN_W{1'b0}}};
            norm_flags = 5'b00101;
        end else if (exp_r[EW-1] || (exp_r == '0)) begin
            norm_q     = {sign, {(W - 1){1'b0}}};
            norm_flags = 5'b00011;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic; specials also pass through StNormRnd so q/flags load in one place.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (in_valid) state_d = StCheck;
            StCheck:   state_d = is_special ? StNormRnd : StIter;
            StIter:    if (cnt_q == CNT_LAST) state_d = StNormRnd;
            StNormRnd: state_d = StDone;
            StDone:    if (out_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            exp_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            qint_q  <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            flags_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q <= a;
                        b_q <= b;
                    end
                end
                StCheck: begin
                    exp_q  <= exp_init;
                    qint_q <= '0;
                    rem_q  <= {1'b0, 1'b1, fa};
                    div_q  <= {1'b1, fb};
                    cnt_q  <= '0;
                end
                StIter: begin
                    rem_q  <= rem_next;
                    qint_q <= {qint_q[MAN_W+1:0], qbit};
                    cnt_q  <= cnt_q + CNT_W'(1);
                end
                StNormRnd: begin
                    q_q     <= is_special ? spec_q : norm_q;
                    flags_q <= is_special ? spec_flags : norm_flags;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDone);
    assign q         = q_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_fp_div_iter.sv
// tb_fp_div_iter: directed and randomized checks of fp_div_iter in FP16 and FP32 builds
// against an exact-arithmetic reference model.
module tb_fp_div_iter;
    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
    logic [15:0] a16, b16, q16;
    logic [4:0]  flags16;
    logic        in_valid32, in_ready32, out_valid32, out_ready32, busy32;
    logic [31:0] a32, b32, q32;
    logic [4:0]  flags32;

    fp_div_iter #(.EXP_W(5), .MAN_W(10)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
        .out_valid(out_valid16), .out_ready(out_ready16), .q(q16), .flags(flags16),
        .busy(busy16)
    );

    fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .a(a32), .b(b32),
        .out_valid(out_valid32), .out_ready(out_ready32), .q(q32), .flags(flags32),
        .busy(busy32)
    );

    int          vectors;
    int          miscompares;
    logic        cur_sel;  // 0: FP16 instance, 1: FP32 instance
    logic        o_valid, o_in_ready, o_busy;
    logic [31:0] o_q;
    logic [4:0]  o_flags;

    always_comb begin
        o_valid    = cur_sel ? out_valid32 : out_valid16;
        o_in_ready = cur_sel ? in_ready32 : in_ready16;
        o_busy     = cur_sel ? busy32 : busy16;
        o_q        = cur_sel ? q32 : {16'h0000, q16};
        o_flags    = cur_sel ? flags32 : flags16;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv);
        if (cur_sel) begin
            in_valid32 = v; a32 = av; b32 = bv;
        end else begin
            in_valid16 = v; a16 = av[15:0]; b16 = bv[15:0];
        end
    endtask

    task automatic set_out_ready(input logic v);
        if (cur_sel) out_ready32 = v;
        else         out_ready16 = v;
    endtask

    // Entered and left #1 after a rising edge with the selected instance idle.
    task automatic do_op(input logic sel, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eq, input logic [4:0] ef, input int elat,
                         input int hold, input string tag);
        int lat;
        cur_sel = sel;
        drive(1'b1, av, bv);
        #0;
        check({tag, " in_ready"}, 32'(o_in_ready), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, $urandom, $urandom);
        check({tag, " busy"}, 32'(o_busy), 32'd1);
        lat = 0;
        while (!o_valid && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " q"}, o_q, eq);
        check({tag, " flags"}, 32'(o_flags), 32'(ef));
        for (int i = 0; i < hold; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, $urandom);
            @(posedge clk); #1;
            check({tag, " hold valid"}, 32'(o_valid), 32'd1);
            check({tag, " hold q"}, o_q, eq);
            check({tag, " hold flags"}, 32'(o_flags), 32'(ef));
        end
        drive(1'b0, 32'h0, 32'h0);
        set_out_ready(1'b1);
        @(posedge clk); #1;
        set_out_ready(1'b0);
        check({tag, " ready after take"}, 32'(o_in_ready), 32'd1);
        check({tag, " valid after take"}, 32'(o_valid), 32'd0);
    endtask

    // Exact reference: integer division with a true remainder decides RNE.
    function automatic void ref_div(input int ew, input int mw, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] q,
                                    output logic [4:0] f, output bit sp);
        longint unsigned emax, fmask, ea, eb, fa, fb, ma, mb, num, sig, r, sgn, quiet;
        bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        int e;
        logic [31:0] inf_v, zero_v, qnan;
        emax   = (64'd1 << ew) - 1;
        fmask  = (64'd1 << mw) - 1;
        ea     = (64'(a) >> mw) & emax;
        eb     = (64'(b) >> mw) & emax;
        fa     = 64'(a) & fmask;
        fb     = 64'(b) & fmask;
        sgn    = ((64'(a) ^ 64'(b)) >> (ew + mw)) & 64'd1;
        quiet  = 64'd1 << (mw - 1);
        a_nan  = (ea == emax) && (fa != 0);
        b_nan  = (eb == emax) && (fb != 0);
        a_inf  = (ea == emax) && (fa == 0);
        b_inf  = (eb == emax) && (fb == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        inf_v  = 32'((sgn << (ew + mw)) | (emax << mw));
        zero_v = 32'(sgn << (ew + mw));
        qnan   = 32'((emax << mw) | quiet);
        f      = '0;
        sp     = 1'b1;
        q      = '0;
        if (a_nan || b_nan) begin
            q    = qnan;
            f[4] = (a_nan && (fa & quiet) == 0) || (b_nan && (fb & quiet) == 0);
        end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            q    = qnan;
            f[4] = 1'b1;
        end else if (a_inf) begin
            q = inf_v;
        end else if (b_inf) begin
            q = zero_v;
        end else if (b_zero) begin
            q    = inf_v;
            f[3] = 1'b1;
        end else if (a_zero) begin
            q = zero_v;
        end else begin
            sp = 1'b0;
            ma = (64'd1 << mw) | fa;
            mb = (64'd1 << mw) | fb;
            e  = int'(ea) - int'(eb) + (1 << (ew - 1)) - 1;
            if (ma >= mb) begin
                num = ma << mw;
            end else begin
                num = ma << (mw + 1);
                e--;
            end
            sig  = num / mb;
            r    = num % mb;
            f[0] = (r != 0);
            if ((2 * r > mb) || (2 * r == mb && sig[0])) sig++;
            if (sig == (64'd1 << (mw + 1))) begin
                sig = sig >> 1;
                e++;
            end
            if (e >= int'(emax)) begin
                q = inf_v;
                f = 5'b00101;
            end else if (e <= 0) begin
                q = zero_v;
                f = 5'b00011;
            end else begin
                q = 32'((sgn << (ew + mw)) | (64'(e) << mw) | (sig & fmask));
            end
        end
    endfunction

    // Random operand mix: zeros, infinities, NaNs, subnormals, near-bias and full-range normals.
    function automatic logic [31:0] rand_op(input int ew, input int mw);
        longint unsigned emax, s, e, f, bias;
        emax = (64'd1 << ew) - 1;
        bias = (64'd1 << (ew - 1)) - 1;
        s    = 64'($urandom_range(0, 1));
        f    = {$urandom, $urandom} & ((64'd1 << mw) - 1);
        e    = bias;
        case ($urandom_range(0, 15))
            0: begin e = 0; f = 0; end
            1: begin e = emax; f = 0; end
            2: begin e = emax; if (f == 0) f = 1; end
            3: e = 0;
            4, 5, 6, 7, 8: e = bias + 64'($urandom_range(0, 6)) - 3;
            default: e = 64'($urandom_range(1, 32'(emax - 1)));
        endcase
        return 32'((s << (ew + mw)) | (e << mw) | f);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb, mq;
        logic [4:0]  mf;
        bit          sp;
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        cur_sel = 1'b0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0;
        in_valid32 = 1'b0; out_ready32 = 1'b0; a32 = '0; b32 = '0;
        #2;
        for (int s = 0; s < 2; s++) begin
            cur_sel = (s == 1);
            #1;
            check("reset out_valid", 32'(o_valid), 32'd0);
            check("reset q", o_q, 32'd0);
            check("reset flags", 32'(o_flags), 32'd0);
            check("reset busy", 32'(o_busy), 32'd0);
            check("reset in_ready", 32'(o_in_ready), 32'd1);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        do_op(1'b0, 32'h4000, 32'h3C00, 32'h4000, 5'h00, 15, 0, "2/1");
        do_op(1'b0, 32'h3C00, 32'h4200, 32'h3555, 5'h01, 15, 6, "1/3 backpressure");

        // Abandon an operation five cycles into the iteration phase.
        cur_sel = 1'b0;
        drive(1'b1, 32'h4000, 32'h3C00);
        @(posedge clk); #1;
        drive(1'b0, 32'h0, 32'h0);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midop rst out_valid", 32'(o_valid), 32'd0);
        check("midop rst q", o_q, 32'd0);
        check("midop rst flags", 32'(o_flags), 32'd0);
        check("midop rst in_ready", 32'(o_in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        check("post rst in_ready", 32'(o_in_ready), 32'd1);
        do_op(1'b0, 32'h4200, 32'h3C00, 32'h4200, 5'h00, 15, 0, "3/1 after rst");

        do_op(1'b0, 32'h3C00, 32'h0000, 32'h7C00, 5'h08, 2, 0, "1/0");
        do_op(1'b0, 32'h0000, 32'h0000, 32'h7E00, 5'h10, 2, 0, "0/0");
        do_op(1'b0, 32'h7D00, 32'h3C00, 32'h7E00, 5'h10, 2, 0, "sNaN/1");
        do_op(1'b0, 32'h7C00, 32'h4000, 32'h7C00, 5'h00, 2, 0, "inf/2");
        do_op(1'b0, 32'h7BFF, 32'h1400, 32'h7C00, 5'h05, 15, 0, "overflow");
        do_op(1'b0, 32'h8400, 32'h4000, 32'h8000, 5'h03, 15, 0, "underflow");
        do_op(1'b0, 32'h0200, 32'h3C00, 32'h0000, 5'h00, 2, 0, "subnormal/1");
        do_op(1'b1, 32'h40490FDB, 32'h40000000, 32'h3FC90FDB, 5'h00, 28, 0, "pi/2 fp32");
        do_op(1'b1, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'h01, 28, 2, "1/3 fp32");

        for (int i = 0; i < 40; i++) begin
            ra = rand_op(5, 10);
            rb = rand_op(5, 10);
            ref_div(5, 10, ra, rb, mq, mf, sp);
            do_op(1'b0, ra, rb, mq, mf, sp ? 2 : 15, $urandom_range(0, 2), "rand fp16");
        end
        for (int i = 0; i < 20; i++) begin
            ra = rand_op(8, 23);
            rb = rand_op(8, 23);
            ref_div(8, 23, ra, rb, mq, mf, sp);
            do_op(1'b1, ra, rb, mq, mf, sp ? 2 : 28, $urandom_range(0, 2), "rand fp32");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
